// File: rtl/adder_digit_serial.sv
// -----------------------------------------------------------------------------
// adder_digit_serial
//
// Digit-serial adder/subtractor. A request is accepted in IDLE, the operands
// are then added one p_nbits_digit-wide digit per cycle (LSB digit first) over
// D = p_nbits/p_nbits_digit CALC cycles, and the result is presented in DONE
// until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. in_rdy is high only in IDLE, out_val only in DONE. While out_val is high
// sum/cout/ovf are stable and held until the next completion or reset.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_val / in_rdy   request handshake
//   in0, in1          operands A and B
//   cin               carry-in for add (ignored when sub=1)
//   sub               0: A+B+cin, 1: A-B computed as A + ~B + 1
//   out_val / out_rdy result handshake
//   sum               result, modulo 2^p_nbits
//   cout              carry out of the MSB (subtract: 1 = no borrow)
//   ovf               two's-complement signed overflow
//   dbg_o             debug view: {latched sub, fsm state}
// -----------------------------------------------------------------------------
module adder_digit_serial #(
    parameter int p_nbits       = 32,
    parameter int p_nbits_digit = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    input  logic               cin,
    input  logic               sub,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic [2:0]         dbg_o
);

    localparam int D  = p_nbits / p_nbits_digit;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int MSB = p_nbits_digit - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [p_nbits-1:0] a_q;
    logic [p_nbits-1:0] b_q;
    logic [p_nbits-1:0] acc_q;
    logic [p_nbits-1:0] sum_q;
    logic               carry_q;
    logic               sub_q;
    logic               cout_q;
    logic               ovf_q;
    logic               in_rdy_q;
    logic               out_val_q;
    logic [CW-1:0]      cnt_q;

    logic [p_nbits_digit-1:0] dig_a;
    logic [p_nbits_digit-1:0] dig_b;
    logic [p_nbits_digit:0]   dsum_d;
    logic                     dcarry_d;
    logic                     dovf_d;
    logic [p_nbits-1:0]       a_d;
    logic [p_nbits-1:0]       b_d;
    logic [p_nbits-1:0]       acc_d;

    // One digit of the addition. The operands are shifted right each cycle so
    // the current digit always sits in the low bits; the digit sum is shifted
    // into the accumulator from the top, so after D cycles the accumulator
    // holds the full result in place.
    always_comb begin
        dig_a    = a_q[p_nbits_digit-1:0];
        dig_b    = b_q[p_nbits_digit-1:0];
        dsum_d   = {1'b0, dig_a} + {1'b0, dig_b} + {{p_nbits_digit{1'b0}}, carry_q};
        dcarry_d = dsum_d[p_nbits_digit];
        // Carry into the digit MSB is a^b^s at that bit; XOR with carry out.
        dovf_d   = dig_a[MSB] ^ dig_b[MSB] ^ dsum_d[MSB] ^ dcarry_d;
        a_d      = a_q >> p_nbits_digit;
        b_d      = b_q >> p_nbits_digit;
        acc_d    = (acc_q >> p_nbits_digit)
                 | (p_nbits'(dsum_d[p_nbits_digit-1:0]) << (p_nbits - p_nbits_digit));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            in_rdy_q  <= 1'b1;
            out_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_val) begin
                        a_q      <= in0;
                        b_q      <= sub ? ~in1 : in1;
                        // Subtract supplies the +1 of the two's complement.
                        carry_q  <= sub | cin;
                        sub_q    <= sub;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        in_rdy_q <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    acc_q   <= acc_d;
                    carry_q <= dcarry_d;
                    if (cnt_q == CW'(D - 1)) begin
                        sum_q     <= acc_d;
                        cout_q    <= dcarry_d;
                        ovf_q     <= dovf_d;
                        out_val_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        out_val_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_val_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_val = out_val_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign dbg_o   = {sub_q, state_q};

endmodule

// File: tb/tb_adder_digit_serial.sv
// -----------------------------------------------------------------------------
// tb_adder_digit_serial
//
// Two instances share clock and reset: u_dut8 uses the default 8-bit digit
// (four CALC cycles), u_dut32 uses a full-width digit (one CALC cycle).
// Expected results come from a reference model and travel through exp_q from
// the moment a request is driven until the DUT presents its result.
// -----------------------------------------------------------------------------
module tb_adder_digit_serial;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT with 8-bit digits ----------------
    logic        in_val, in_rdy, cin, sub, out_val, out_rdy, cout, ovf;
    logic [31:0] in0, in1, sum;
    logic [2:0]  dbg8;

    adder_digit_serial #(.p_nbits(32), .p_nbits_digit(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_val(in_val), .in_rdy(in_rdy),
        .in0(in0), .in1(in1), .cin(cin), .sub(sub),
        .out_val(out_val), .out_rdy(out_rdy),
        .sum(sum), .cout(cout), .ovf(ovf),
        .dbg_o(dbg8)
    );

    // ---------------- DUT with one full-width digit ----------------
    logic        in_val1, in_rdy1, cin1, sub1, out_val1, out_rdy1, cout1, ovf1;
    logic [31:0] in0_1, in1_1, sum1;
    logic [2:0]  dbg32;

    adder_digit_serial #(.p_nbits(32), .p_nbits_digit(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_val(in_val1), .in_rdy(in_rdy1),
        .in0(in0_1), .in1(in1_1), .cin(cin1), .sub(sub1),
        .out_val(out_val1), .out_rdy(out_rdy1),
        .sum(sum1), .cout(cout1), .ovf(ovf1),
        .dbg_o(dbg32)
    );

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];   // {cout, ovf, sum}
    int total = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width sum with explicit carry, overflow from operand signs.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        logic [31:0] be;
        logic        ce;
        logic [32:0] full;
        logic        ov;
        be   = s ? ~b : b;
        ce   = s ? 1'b1 : c;
        full = {1'b0, a} + {1'b0, be} + {32'd0, ce};
        ov   = (a[31] == be[31]) && (full[31] != a[31]);
        return {full[32], ov, full[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver for u_dut8 ----------------
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input int hold);
        int          n;
        logic [33:0] exp;
        logic [31:0] held;
        n = 0;
        while (!in_rdy && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
        in0    = a;
        in1    = b;
        cin    = c;
        sub    = s;
        in_val = 1'b1;
        exp_q.push_back(model(a, b, c, s));
        tick();                      // accepting edge
        in_val = 1'b0;
        // Scramble operand inputs mid-operation; they must be ignored.
        in0 = $urandom;
        in1 = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_val && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        exp = exp_q.pop_front();
        check({tag, "_result"}, 64'({cout, ovf, sum}), 64'(exp));
        check({tag, "_rdy_in_done"}, 64'(in_rdy), 64'd0);
        held = sum;
        for (int i = 0; i < hold; i++) begin
            out_rdy = 1'b0;
            tick();
            check({tag, "_hold_val"}, 64'(out_val), 64'd1);
            check({tag, "_hold_rdy"}, 64'(in_rdy), 64'd0);
            check({tag, "_hold_sum"}, 64'(sum), 64'(held));
        end
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check({tag, "_back_idle_val"}, 64'(out_val), 64'd0);
        check({tag, "_back_idle_rdy"}, 64'(in_rdy), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic        saw_val;
        logic [33:0] exp;

        rst = 1'b1;
        in_val = 1'b0; out_rdy = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; sub = 1'b0;
        in_val1 = 1'b0; out_rdy1 = 1'b0; in0_1 = '0; in1_1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_result", 64'({cout, ovf, sum}), 64'd0);
        check("rst_in_rdy32", 64'(in_rdy1), 64'd1);
        check("rst_out_val32", 64'(out_val1), 64'd0);

        // Directed arithmetic cases, including backpressure on the third.
        run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        run_op("sub_cin0",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 3);
        run_op("sub_cin1",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        run_op("add_cin",    32'h1234_00FF, 32'h0000_0F01, 1'b1, 1'b0, 1);
        run_op("sub_negovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);

        // Reset during the second CALC cycle aborts the operation.
        in0 = 32'h0000_1111; in1 = 32'h0000_2222; cin = 1'b0; sub = 1'b0;
        in_val = 1'b1;
        tick();                      // accepted, first CALC cycle
        in_val = 1'b0;
        tick();                      // second CALC cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_rdy", 64'(in_rdy), 64'd1);
        check("abort_out_val", 64'(out_val), 64'd0);
        check("abort_result", 64'({cout, ovf, sum}), 64'd0);
        saw_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_val = saw_val | out_val;
        end
        check("abort_no_out_val", 64'(saw_val), 64'd0);
        run_op("after_abort", 32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0, 0);

        // Random operations with random backpressure.
        for (int i = 0; i < 6; i++) begin
            run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Full-width digit: one-cycle latency and back-to-back requests.
        in0_1 = 32'h0000_0010; in1_1 = 32'h0000_0020; cin1 = 1'b1; sub1 = 1'b0;
        in_val1 = 1'b1; out_rdy1 = 1'b1;
        exp_q.push_back(model(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0));
        tick();                      // accept #1
        check("w32_calc_rdy", 64'(in_rdy1), 64'd0);
        check("w32_calc_val", 64'(out_val1), 64'd0);
        // Next request already presented; ignored until IDLE.
        in0_1 = 32'hFFFF_FFF0; in1_1 = 32'h0000_0020; cin1 = 1'b0; sub1 = 1'b1;
        exp_q.push_back(model(32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b1));
        tick();                      // DONE, one edge after acceptance
        check("w32_done_val", 64'(out_val1), 64'd1);
        check("w32_done_rdy", 64'(in_rdy1), 64'd0);
        exp = exp_q.pop_front();
        check("w32_result1", 64'({cout1, ovf1, sum1}), 64'(exp));
        tick();                      // back in IDLE: the single idle cycle
        check("w32_idle_rdy", 64'(in_rdy1), 64'd1);
        check("w32_idle_val", 64'(out_val1), 64'd0);
        tick();                      // accept #2
        in_val1 = 1'b0;
        check("w32_calc2_rdy", 64'(in_rdy1), 64'd0);
        tick();
        check("w32_done2_val", 64'(out_val1), 64'd1);
        exp = exp_q.pop_front();
        check("w32_result2", 64'({cout1, ovf1, sum1}), 64'(exp));
        tick();
        out_rdy1 = 1'b0;
        check("w32_final_rdy", 64'(in_rdy1), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/adder_digit_serial.md
ADDER_DIGIT_SERIAL -- requirements
Module: adder_digit_serial

Interface
REQ-001 Parameter: p_nbits, default 32, operand and result width in bits.
REQ-002 Parameter: p_nbits_digit, default 8, bits added per cycle; p_nbits SHALL be an integer multiple of p_nbits_digit.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_val  input  1  request valid.
REQ-006 Port: in_rdy  output  1  block can accept a request.
REQ-007 Port: in0  input  p_nbits  operand A.
REQ-008 Port: in1  input  p_nbits  operand B.
REQ-009 Port: cin  input  1  carry-in for add; ignored for subtract.
REQ-010 Port: sub  input  1  0 = A+B+cin, 1 = A-B (computed as A + ~B + 1).
REQ-011 Port: out_val  output  1  result valid.
REQ-012 Port: out_rdy  input  1  consumer can take the result.
REQ-013 Port: sum  output  p_nbits  result.
REQ-014 Port: cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-015 Port: ovf  output  1  two's-complement signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-016 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-017 in_rdy SHALL be 1 only in IDLE; out_val SHALL be 1 only in DONE.
REQ-018 On in_val & in_rdy, the block SHALL latch in0, in1 (inverted when sub=1), the effective carry-in (cin, or 1 when sub=1) and sub, clear the digit counter, and move to CALC.
REQ-019 While in_val is 0 in IDLE, the block SHALL stay in IDLE with no state change.
REQ-020 In CALC, each cycle SHALL add one p_nbits_digit-bit digit of the latched operands, LSB digit first, plus the registered carry, storing the digit sum and the digit carry-out.
REQ-021 CALC SHALL last exactly D = p_nbits/p_nbits_digit cycles; the D-th CALC edge SHALL enter DONE.
REQ-022 out_val SHALL rise D rising edges after the accepting edge (D=4 by default; D=1 when p_nbits_digit = p_nbits).
REQ-023 sum, cout and ovf SHALL update only on the edge entering DONE and SHALL hold their values until the next completion or reset.
REQ-024 In DONE, the block SHALL stay in DONE while out_rdy is 0, with all outputs stable.
REQ-025 On out_val & out_rdy, the block SHALL return to IDLE; a new request SHALL NOT be accepted on that same edge (in_rdy is 0 in DONE).
REQ-026 Inputs in0, in1, cin, sub and in_val SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the result.
REQ-027 Arithmetic SHALL be modulo 2^p_nbits; cout and ovf SHALL be taken from the MSB digit of the final cycle only.

Reset
REQ-028 While rst is 1 at a rising edge, the FSM SHALL enter IDLE and clear the digit counter and internal carry; sum, cout and ovf SHALL be 0, out_val SHALL be 0 and in_rdy SHALL be 1 from the next cycle.
REQ-029 Reset asserted in CALC or DONE SHALL abort the operation; no out_val SHALL be produced for the aborted request.
REQ-030 rst SHALL take priority over in_val and out_rdy on the same edge.

Verification
REQ-031 Default parameters, add 0xFFFFFFFF + 0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0; out_val rises 4 edges after acceptance.
REQ-032 Add 0x7FFFFFFF + 0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-033 sub=1, 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0; with cin=1 applied, the result SHALL be identical.
REQ-034 Backpressure: hold out_rdy=0 for 3 cycles in DONE -> out_val stays 1, in_rdy stays 0, sum is stable; with out_rdy=1 -> IDLE on the next edge.
REQ-035 Assert rst on the 2nd CALC cycle -> IDLE next cycle, sum=0, out_val never asserted; a following request completes correctly.
REQ-036 p_nbits_digit=32: add 0x00000010 + 0x00000020, cin=1 -> sum=0x00000031, out_val 1 edge after acceptance; back-to-back requests SHALL show one idle in_rdy cycle between acceptances.
